// File: rtl/ram_pkg.sv
// Shared sizing constants and word/address types for the generic scratch RAM.
package ram_pkg;

    localparam int RAM_ADDR_WIDTH = 8;
    localparam int RAM_DATA_WIDTH = 64;
    localparam int RAM_DEPTH      = 2 ** RAM_ADDR_WIDTH;

    typedef logic [RAM_ADDR_WIDTH-1:0] ram_addr_t;
    typedef logic [RAM_DATA_WIDTH-1:0] ram_data_t;

endpackage

// File: rtl/ram.sv
// Single-port word-addressed scratch RAM with chip enable and write enable.
// Latency: registered read data one cycle after the address edge; writes land on the sampling edge.
// Backpressure: none; accepts one read or write every cycle.
module ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cen,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [DATA_WIDTH-1:0] s_din,
    output logic [DATA_WIDTH-1:0] s_dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reset wipes the whole array, so storage is flops rather than a macro;
    // s_dout returns zero on any cycle that is not a read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_dout <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            s_dout <= '0;
            if (cen) begin
                if (wen) begin
                    mem[s_addr] <= s_din;
                end else begin
                    s_dout <= mem[s_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_ram.sv
module tb_ram;
    import ram_pkg::*;

    logic      clk = 1'b0;
    logic      reset_n = 1'b1;
    logic      cen = 1'b0;
    logic      wen = 1'b0;
    ram_addr_t s_addr = '0;
    ram_data_t s_din = '0;
    ram_data_t s_dout;

    int checks = 0;
    int failures = 0;

    ram_data_t model [RAM_DEPTH];
    ram_data_t sb [$];

    ram #(
        .DATA_WIDTH(RAM_DATA_WIDTH),
        .ADDR_WIDTH(RAM_ADDR_WIDTH),
        .DEPTH     (RAM_DEPTH)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .cen    (cen),
        .wen    (wen),
        .s_addr (s_addr),
        .s_din  (s_din),
        .s_dout (s_dout)
    );

    always #5 clk = ~clk;

    task automatic clear_model();
        for (int i = 0; i < RAM_DEPTH; i++) model[i] = '0;
        sb.delete();
    endtask

    // Drive one access for the next edge and record what s_dout must show after it.
    task automatic step(input logic c, input logic w, input ram_addr_t a, input ram_data_t d);
        @(negedge clk);
        cen = c; wen = w; s_addr = a; s_din = d;
        if (c && !w) sb.push_back(model[a]);
        else         sb.push_back('0);
        if (c && w) model[a] = d;
    endtask

    task automatic test_reset();
        ram_data_t exp;
        ram_addr_t addrs [3] = '{8'h00, 8'h3F, 8'hFF};
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (s_dout !== '0) begin
            failures++;
            $display("FAIL reset_immediate: s_dout=%h expected=%h", s_dout, 64'h0);
        end
        // A write presented while reset is held must not land.
        @(negedge clk);
        cen = 1'b1; wen = 1'b1; s_addr = 8'h3F; s_din = 64'h1234_5678_9ABC_DEF0;
        @(posedge clk); #1;
        checks++;
        if (s_dout !== '0) begin
            failures++;
            $display("FAIL reset_hold: s_dout=%h expected=%h", s_dout, 64'h0);
        end
        @(negedge clk);
        reset_n = 1'b1; cen = 1'b0; wen = 1'b0;
        clear_model();
        foreach (addrs[i]) begin
            step(1'b1, 1'b0, addrs[i], '0);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (s_dout !== exp) begin
                failures++;
                $display("FAIL reset_read[%h]: s_dout=%h expected=%h", addrs[i], s_dout, exp);
            end
        end
    endtask

    task automatic test_chip_disabled();
        ram_data_t exp;
        step(1'b0, 1'b1, 8'h00, 64'h0000_FFFF);
        step(1'b1, 1'b0, 8'h00, '0);
        for (int i = 0; i < 2; i++) begin
            if (i == 0) @(posedge clk);
            else        @(posedge clk);
        end
        // both steps already queued; replay their checks in order is not possible
        // after the fact, so this task checks the final edge only
        exp = sb.pop_front();
        exp = sb.pop_front();
        #1;
        checks++;
        if (s_dout !== exp) begin
            failures++;
            $display("FAIL cen_off_no_write: s_dout=%h expected=%h", s_dout, exp);
        end
    endtask

    task automatic test_write_read();
        ram_data_t exp;
        logic      wr   [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic      en   [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        ram_addr_t ad   [9] = '{8'h00, 8'h3F, 8'hFF, 8'h00, 8'h3F, 8'hFF, 8'h3F, 8'h3F, 8'hFF};
        ram_data_t dt   [9] = '{64'h0000_FFFF, 64'h00FF_FF00, 64'hFFFF_0000, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        for (int i = 0; i < 9; i++) begin
            step(en[i], wr[i], ad[i], dt[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (s_dout !== exp) begin
                failures++;
                $display("FAIL write_read[%0d] addr=%h: s_dout=%h expected=%h", i, ad[i], s_dout, exp);
            end
        end
    endtask

    task automatic test_read_after_write();
        ram_data_t exp;
        step(1'b1, 1'b1, 8'h80, 64'hDEAD_BEEF_CAFE_F00D);
        @(posedge clk); #1;
        exp = sb.pop_front();
        checks++;
        if (s_dout !== exp) begin
            failures++;
            $display("FAIL raw_write: s_dout=%h expected=%h", s_dout, exp);
        end
        step(1'b1, 1'b0, 8'h80, '0);
        @(posedge clk); #1;
        exp = sb.pop_front();
        checks++;
        if (s_dout !== exp) begin
            failures++;
            $display("FAIL raw_read: s_dout=%h expected=%h", s_dout, exp);
        end
    endtask

    task automatic test_boundary();
        ram_data_t exp;
        logic      wr [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        ram_addr_t ad [6] = '{8'hFF, 8'h00, 8'hFF, 8'h7F, 8'h00, 8'h3F};
        ram_data_t dt [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555, 64'h0,
                              64'hA5A5_0000_1111_2222, 64'h0, 64'h0};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, wr[i], ad[i], dt[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (s_dout !== exp) begin
                failures++;
                $display("FAIL boundary[%0d] addr=%h: s_dout=%h expected=%h", i, ad[i], s_dout, exp);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        ram_data_t exp;
        ram_addr_t addrs [4] = '{8'h00, 8'h3F, 8'hFF, 8'h80};
        step(1'b1, 1'b0, 8'hFF, '0);
        @(posedge clk); #1;
        exp = sb.pop_front();
        checks++;
        if (s_dout !== exp) begin
            failures++;
            $display("FAIL midrst_preread: s_dout=%h expected=%h", s_dout, exp);
        end
        // Queue a write, then pull reset between edges before it is sampled.
        cen = 1'b1; wen = 1'b1; s_addr = 8'h00; s_din = 64'h0BAD_0BAD_0BAD_0BAD;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (s_dout !== '0) begin
            failures++;
            $display("FAIL midrst_immediate: s_dout=%h expected=%h", s_dout, 64'h0);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1; cen = 1'b0; wen = 1'b0;
        clear_model();
        foreach (addrs[i]) begin
            step(1'b1, 1'b0, addrs[i], '0);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (s_dout !== exp) begin
                failures++;
                $display("FAIL midrst_read[%h]: s_dout=%h expected=%h", addrs[i], s_dout, exp);
            end
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_chip_disabled();
        test_write_read();
        test_read_after_write();
        test_boundary();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation time=%0t limit=%0d", $time, 50000);
        $fatal(1, "timeout");
    end

endmodule
